// File: rtl/tb_clk_divider.sv
// Programmable clock divider with a glitch-free registered output clock,
// a tick strobe on each rising phase, and a valid/ack divisor update
// that only takes effect on period boundaries or while idle.
module tb_clk_divider #(
  parameter int DIV_WIDTH = 8,
  parameter int RESET_DIV = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic [DIV_WIDTH-1:0] cfg_div_i,
  input  logic                 cfg_valid_i,
  output logic                 cfg_ack_o,
  output logic                 busy_o,
  output logic                 clk_o,
  output logic                 tick_o
);

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  localparam logic [DIV_WIDTH-1:0] RESET_DIV_W = DIV_WIDTH'(RESET_DIV);
  localparam logic [DIV_WIDTH-1:0] ONE_W       = DIV_WIDTH'(1);
  localparam logic [DIV_WIDTH:0]   ONE_X       = (DIV_WIDTH + 1)'(1);

  state_e               state_q, state_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [DIV_WIDTH-1:0] shadow_q, shadow_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic                 pend_q, pend_d;
  logic                 clk_q, clk_d;
  logic                 tick_q, tick_d;
  logic                 ack_q, ack_d;

  logic [DIV_WIDTH-1:0] cur_n;
  logic [DIV_WIDTH:0]   half_n;
  logic [DIV_WIDTH:0]   cnt_inc;
  logic                 period_end;
  logic                 apply;
  logic [DIV_WIDTH-1:0] next_div;

  // A divisor of 1 would need a zero-length low phase, so it runs as 2.
  function automatic logic [DIV_WIDTH-1:0] eff_n(input logic [DIV_WIDTH-1:0] d);
    return (d == ONE_W) ? DIV_WIDTH'(2) : d;
  endfunction

  // Period arithmetic is done one bit wider so N+1 cannot overflow at the max divisor.
  assign cur_n      = eff_n(div_q);
  assign half_n     = ({1'b0, cur_n} + ONE_X) >> 1;
  assign cnt_inc    = {1'b0, cnt_q} + ONE_X;
  assign period_end = (div_q == '0) || (cnt_q == cur_n - ONE_W);
  assign apply      = pend_q && ((state_q == IDLE) || period_end);
  assign next_div   = apply ? shadow_q : div_q;

  // Next-state logic: config handshake, then period sequencing.
  always_comb begin
    // NOTE: every _d gets a default first so no path leaves a latch behind.
    state_d  = state_q;
    div_d    = div_q;
    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    pend_d   = pend_q;
    clk_d    = clk_q;
    tick_d   = 1'b0;
    ack_d    = 1'b0;

    if (apply) begin
      div_d  = shadow_q;
      pend_d = 1'b0;
      ack_d  = 1'b1;
    end else if (!pend_q && cfg_valid_i) begin
      shadow_d = cfg_div_i;
      pend_d   = 1'b1;
    end

    if ((state_q == RUN) && !period_end) begin
      cnt_d = cnt_q + ONE_W;
      clk_d = (cnt_inc < half_n);
    end else if (en_i && (next_div != '0)) begin
      state_d = RUN;
      cnt_d   = '0;
      clk_d   = 1'b1;
      tick_d  = 1'b1;
    end else begin
      state_d = IDLE;
      cnt_d   = '0;
      clk_d   = 1'b0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    // NOTE: reset is sampled on the clock edge, so it sits inside the edge-only block.
    if (rst_i) begin
      state_q  <= IDLE;
      div_q    <= RESET_DIV_W;
      shadow_q <= '0;
      cnt_q    <= '0;
      pend_q   <= 1'b0;
      clk_q    <= 1'b0;
      tick_q   <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register updates from the same pre-edge values.
      state_q  <= state_d;
      div_q    <= div_d;
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      clk_q    <= clk_d;
      tick_q   <= tick_d;
      ack_q    <= ack_d;
    end
  end

  assign clk_o     = clk_q;
  assign tick_o    = tick_q;
  assign cfg_ack_o = ack_q;
  assign busy_o    = pend_q;

endmodule

// File: tb/tb_tb_clk_divider.sv
// Scoreboard bench for tb_clk_divider: a waveform-queue reference model
// predicts every output cycle; a separate monitor compares after each edge.
module tb_tb_clk_divider;

  localparam int DW        = 8;
  localparam int RESET_DIV = 2;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          en_i = 1'b0;
  logic [DW-1:0] cfg_div_i = '0;
  logic          cfg_valid_i = 1'b0;
  logic          cfg_ack_o, busy_o, clk_o, tick_o;

  tb_clk_divider #(.DIV_WIDTH(DW), .RESET_DIV(RESET_DIV)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .en_i        (en_i),
    .cfg_div_i   (cfg_div_i),
    .cfg_valid_i (cfg_valid_i),
    .cfg_ack_o   (cfg_ack_o),
    .busy_o      (busy_o),
    .clk_o       (clk_o),
    .tick_o      (tick_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic clk;
    logic tick;
    logic ack;
    logic busy;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cycle = 0;

  // Reference model: a divisor, a pending request, and a queue holding
  // the remaining {clk,tick} samples of the current period.
  int       m_div = RESET_DIV;
  bit       m_pend = 1'b0;
  int       m_shadow = 0;
  int       m_caps = 0;
  bit [1:0] wave[$];
  exp_t     last_e;

  task automatic check(input string name, input logic act, input logic req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %b, expected %b", name, cycle, act, req);
    end
  endtask

  task automatic step(input bit rst, input bit en, input bit valid, input int d);
    exp_t     e;
    bit [1:0] w;
    bit       applied;
    int       n;
    int       h;
    @(negedge clk_i);
    rst_i       = rst;
    en_i        = en;
    cfg_valid_i = valid;
    cfg_div_i   = d[DW-1:0];
    e = '0;
    if (rst) begin
      m_div  = RESET_DIV;
      m_pend = 1'b0;
      wave.delete();
    end else begin
      applied = 1'b0;
      if (wave.size() == 0 && m_pend) begin
        m_div   = m_shadow;
        m_pend  = 1'b0;
        applied = 1'b1;
      end else if (!m_pend && valid) begin
        m_pend   = 1'b1;
        m_shadow = d % (1 << DW);
        m_caps++;
      end
      if (wave.size() == 0 && en && m_div != 0) begin
        n = (m_div == 1) ? 2 : m_div;
        h = (n + 1) / 2;
        for (int i = 0; i < n; i++) wave.push_back({(i < h) ? 1'b1 : 1'b0, (i == 0) ? 1'b1 : 1'b0});
      end
      w = (wave.size() > 0) ? wave.pop_front() : 2'b00;
      e.clk  = w[1];
      e.tick = w[0];
      e.ack  = applied;
      e.busy = m_pend;
    end
    last_e = e;
    exp_q.push_back(e);
  endtask

  // Monitor: compares the DUT against the oldest prediction after each edge.
  always @(posedge clk_i) begin
    exp_t e;
    #1;
    cycle++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("clk_o", clk_o, e.clk);
      check("tick_o", tick_o, e.tick);
      check("cfg_ack_o", cfg_ack_o, e.ack);
      check("busy_o", busy_o, e.busy);
    end
  end

  initial begin
    int vals[3];
    int base;
    int k;
    vals[0] = 5; vals[1] = 7; vals[2] = 2;

    // Reset, then free-run at the reset divisor.
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 1, 0, 0);

    // Request D=5 during a high phase.
    k = 0;
    while (!last_e.clk && k < 10) begin step(0, 1, 0, 0); k++; end
    step(0, 1, 1, 5);
    for (int i = 0; i < 16; i++) step(0, 1, 0, 0);

    // Switch to D=4, then drop enable at cnt=1 and reassert later.
    step(0, 1, 1, 4);
    for (int i = 0; i < 8; i++) step(0, 1, 0, 0);
    k = 0;
    while (!(last_e.tick == 1'b0 && wave.size() == 2) && k < 20) begin step(0, 1, 0, 0); k++; end
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 1, 0, 0);

    // D=1 behaves as 2; D=0 stops; D=3 from idle restarts.
    step(0, 1, 1, 1);
    for (int i = 0; i < 8; i++) step(0, 1, 0, 0);
    step(0, 1, 1, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 0, 0);
    step(0, 1, 1, 3);
    for (int i = 0; i < 10; i++) step(0, 1, 0, 0);

    // Back-to-back requests with cfg_valid_i held high.
    base = m_caps;
    k = 0;
    while (m_caps < base + 3 && k < 200) begin
      step(0, 1, 1, vals[m_caps - base]);
      k++;
    end
    for (int i = 0; i < 10; i++) step(0, 1, 0, 0);

    // Reset mid high phase with a request pending.
    step(0, 1, 1, 9);
    k = 0;
    while (!last_e.clk && k < 10) begin step(0, 1, 0, 0); k++; end
    step(1, 1, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 0, 0);

    // Maximum divisor for one period.
    step(0, 1, 1, 255);
    for (int i = 0; i < 520; i++) step(0, 1, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      int d;
      d = ($urandom_range(0, 15) == 0) ? $urandom_range(250, 255) : $urandom_range(0, 9);
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) != 0),
           ($urandom_range(0, 7) == 0), d);
    end

    repeat (3) @(negedge clk_i);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL queue_drained: %0d predictions left, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tb_clk_divider.md
Name: tb_clk_divider

Overview:
Synthesizable programmable clock divider that consumes the clock produced by the testbench/SoC clock generator. It emits a registered, glitch-free divided clock and a one-cycle tick strobe. The divisor is reconfigured at runtime through a valid/ack handshake, and new values are applied only at period boundaries. It sits directly downstream of the clock source and feeds peripheral or slow-domain clocks.

Parameters:
DIV_WIDTH, 8, width of the divisor and of the internal counter
RESET_DIV, 2, divisor value loaded at reset (must be < 2^DIV_WIDTH)

Ports:
clk_i  input  1  source clock; the only clock in the block
rst_i  input  1  synchronous, active-high reset
en_i  input  1  divider enable
cfg_div_i  input  DIV_WIDTH  requested divisor D
cfg_valid_i  input  1  configuration request
cfg_ack_o  output  1  one-cycle pulse when the requested divisor is applied
busy_o  output  1  a captured request is pending application
clk_o  output  1  divided clock, driven directly from a flop
tick_o  output  1  high exactly in the first clk_i cycle of each clk_o high phase

Behaviour:
- Reset (rst_i=1 at a clk_i edge): div_q=RESET_DIV, cnt_q=0, state=IDLE, pending=0. Outputs: clk_o=0, tick_o=0, cfg_ack_o=0, busy_o=0. Reset takes priority over everything, including mid-period and mid-handshake; a dropped pending request produces no ack.
- Effective divisor: N = 2 if div_q = 1, N = div_q if div_q >= 2. div_q = 0 means stopped.
- Phase lengths: H = ceil(N/2) (high phase), L = N - H (low phase, always >= 1). Period is N clk_i cycles. Example: N=5 gives 3 cycles high, 2 low.
- FSM states IDLE and RUN:
  - IDLE: cnt_q=0, clk_o=0.
  - IDLE -> RUN when en_i=1 and effective div_q != 0. On that edge: cnt_q <= 0, clk_o <= 1, tick_o <= 1. clk_o is therefore high one cycle after en_i is sampled high.
  - RUN, cnt_q < N-1: cnt_q <= cnt_q+1; clk_o <= ((cnt_q+1) < H); tick_o <= 0.
  - RUN, cnt_q = N-1 (period boundary): first apply any pending config. Then, if en_i=1 and the new div != 0: restart with cnt_q <= 0, clk_o <= 1, tick_o <= 1. Otherwise go to IDLE with clk_o <= 0.
  - en_i is ignored mid-period. The current period always completes, so there are no runt pulses.
- Config handshake:
  - In the cycle where pending=0 and cfg_valid_i=1, cfg_div_i is captured into a shadow register and pending <= 1. busy_o mirrors pending.
  - While pending=1, cfg_valid_i is ignored.
  - Apply point: the next RUN boundary edge, or the next edge if state is IDLE. On that edge: div_q <= shadow, pending <= 0, and cfg_ack_o = 1 for exactly one cycle.
  - At a boundary, the newly applied divisor governs the period that starts on the same edge.
  - cfg_valid_i still high in the cycle after ack is treated as a new request.
- Simultaneous events at a boundary: config apply and en_i=0 are both honoured, giving ack plus a transition to IDLE. Applying D=0 gives ack plus a transition to IDLE.
- Counter: cnt_q is DIV_WIDTH bits and never exceeds N-1. The maximum divisor is 2^DIV_WIDTH - 1, with no wrap-around path.
- All outputs are registered, with no combinational path from inputs to outputs.

Test Plan:
1. Reset with RESET_DIV=2, then en_i=1 from cycle 0. Expect clk_o = 1,0,1,0,... starting cycle 1, tick_o high in cycles 1,3,5,..., cfg_ack_o=0 and busy_o=0 throughout.
2. Running at D=2, pulse cfg_valid_i with cfg_div_i=5 during a high phase. Expect busy_o=1 until the boundary, one ack pulse on the boundary, then clk_o high 3 cycles / low 2 cycles repeating, with tick_o every 5 cycles.
3. Running at D=4, drop en_i at cnt=1. Expect clk_o to finish as 1,0,0 to the end of the period and then stay 0, tick_o to stop, and state IDLE. Reassert en_i: clk_o=1 the next cycle.
4. Apply D=1: expect period 2 (identical to D=2). Then apply D=0: expect ack at the boundary and clk_o held at 0 while en_i=1. Then apply D=3 while IDLE: expect ack the next cycle and clk_o to restart with a 2-high / 1-low pattern.
5. Hold cfg_valid_i high across 3 back-to-back requests (5, 7, 2). Expect each captured only after the previous ack, one ack per apply, and each period length matching its applied divisor.
6. Assert rst_i during a clk_o high phase with a request pending. Expect, on the next cycle: clk_o=0, busy_o=0, no ack, div=RESET_DIV; output resumes one cycle after rst_i is released with en_i=1.
